// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param
// Parametrised vending-machine controller. Accumulates 5- and 10-unit coins
// up to PRICE, pulses dispense for one cycle, then pays back any excess
// credit as a train of 5-unit change pulses. A cancel in COLLECT refunds
// the held credit the same way. Deposits that would push credit above
// MAX_CREDIT are rejected whole, as is any coin offered while busy.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   coin_5       one 5-unit coin per cycle sampled high
//   coin_10      one 10-unit coin per cycle sampled high
//   cancel       refund request, honoured only in COLLECT
//   dispense     one-cycle product release pulse
//   change_5     one pulse per 5 units returned
//   coin_reject  coin(s) sampled on the previous edge were not accepted
//   busy         high while dispensing or returning change
//   credit       current credit held
module vend_ctrl_param #(
   parameter int PRICE      = 20,
   parameter int MAX_CREDIT = 40,
   parameter int CW         = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          coin_5,
   input  logic          coin_10,
   input  logic          cancel,
   output logic          dispense,
   output logic          change_5,
   output logic          coin_reject,
   output logic          busy,
   output logic [CW-1:0] credit
);

   localparam int CWX = CW + 1;

   // Extended-width constants keep the ceiling and price comparisons free
   // of wrap-around when a deposit lands near the top of the register.
   localparam logic [CW:0]   PriceExt = CWX'(PRICE);
   localparam logic [CW:0]   MaxExt   = CWX'(MAX_CREDIT);
   localparam logic [CW:0]   FiveExt  = CWX'(5);
   localparam logic [CW:0]   TenExt   = CWX'(10);
   localparam logic [CW-1:0] PriceW   = CW'(PRICE);
   localparam logic [CW-1:0] FiveW    = CW'(5);

   typedef enum logic [1:0] {
      COLLECT,
      DISPENSE,
      RETURN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          reject_q, reject_d;

   logic [CW:0]   deposit;
   logic [CW:0]   sum;
   logic [CW-1:0] remainder;
   logic          anyCoin;

   // Deposit for this cycle; both coins together form one 15-unit deposit
   // so the ceiling check accepts or rejects them as a unit.
   always_comb begin
      deposit = '0;
      if (coin_5) begin
         deposit = deposit + FiveExt;
      end
      if (coin_10) begin
         deposit = deposit + TenExt;
      end
   end

   assign anyCoin   = coin_5 | coin_10;
   assign sum       = {1'b0, credit_q} + deposit;
   assign remainder = credit_q - PriceW;

   // Next-state logic. In COLLECT, cancel outranks coins, so a coin offered
   // alongside cancel is always rejected even when there is nothing to
   // refund. In the busy states every offered coin is rejected.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;
      case (state_q)
         COLLECT: begin
            if (cancel) begin
               reject_d = anyCoin;
               if (credit_q != '0) begin
                  state_d = RETURN;
               end
            end else if (anyCoin) begin
               if (sum <= MaxExt) begin
                  credit_d = sum[CW-1:0];
                  if (sum >= PriceExt) begin
                     state_d = DISPENSE;
                  end
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         DISPENSE: begin
            reject_d = anyCoin;
            credit_d = remainder;
            state_d  = (remainder != '0) ? RETURN : COLLECT;
         end
         RETURN: begin
            reject_d = anyCoin;
            // Credit is always a multiple of 5 here; the <= guard just keeps
            // a corrupted value from underflowing into a long payout.
            if (credit_q <= FiveW) begin
               credit_d = '0;
               state_d  = COLLECT;
            end else begin
               credit_d = credit_q - FiveW;
            end
         end
         default: begin
            state_d  = COLLECT;
            credit_d = '0;
         end
      endcase
   end

   // State, credit and reject flag registers. Reset discards any held
   // credit without paying change.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= COLLECT;
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         reject_q <= reject_d;
      end
   end

   assign dispense    = (state_q == DISPENSE);
   assign change_5    = (state_q == RETURN);
   assign busy        = (state_q == DISPENSE) || (state_q == RETURN);
   assign coin_reject = reject_q;
   assign credit      = credit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param
// Directed bench for vend_ctrl_param. The main instance uses PRICE=20,
// MAX_CREDIT=40; a second instance with MAX_CREDIT=20 shares the inputs
// and is only examined in the ceiling scenario.
module tb_vend_ctrl_param;

   logic       clk;
   logic       reset;
   logic       coin5;
   logic       coin10;
   logic       cancelReq;

   logic       dispense, change5, coinReject, busy;
   logic [5:0] credit;
   logic       dispense2, change52, coinReject2, busy2;
   logic [5:0] credit2;

   int errors;
   int checks;

   vend_ctrl_param #(.PRICE(20), .MAX_CREDIT(40), .CW(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .coin_5      (coin5),
      .coin_10     (coin10),
      .cancel      (cancelReq),
      .dispense    (dispense),
      .change_5    (change5),
      .coin_reject (coinReject),
      .busy        (busy),
      .credit      (credit)
   );

   vend_ctrl_param #(.PRICE(20), .MAX_CREDIT(20), .CW(6)) dutCeil (
      .clk         (clk),
      .reset       (reset),
      .coin_5      (coin5),
      .coin_10     (coin10),
      .cancel      (cancelReq),
      .dispense    (dispense2),
      .change_5    (change52),
      .coin_reject (coinReject2),
      .busy        (busy2),
      .credit      (credit2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Holds the given inputs across one rising edge, then samples 1 time
   // unit after the edge with inputs back at idle.
   task automatic applyStimulus(input logic c5, input logic c10, input logic can);
      coin5     = c5;
      coin10    = c10;
      cancelReq = can;
      @(posedge clk);
      #1;
      coin5     = 1'b0;
      coin10    = 1'b0;
      cancelReq = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL reset_credit: got %0d expected 0", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("[TB] FAIL reset_dispense: got %b expected 0", dispense); end
      checks++; if (change5 !== 1'b0) begin errors++; $display("[TB] FAIL reset_change: got %b expected 0", change5); end
      checks++; if (coinReject !== 1'b0) begin errors++; $display("[TB] FAIL reset_reject: got %b expected 0", coinReject); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_exact_price();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (credit !== 6'd5) begin errors++; $display("[TB] FAIL exact_credit5: got %0d expected 5", credit); end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (credit !== 6'd15) begin errors++; $display("[TB] FAIL exact_credit15: got %0d expected 15", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("[TB] FAIL exact_early_dispense: got %b expected 0", dispense); end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (credit !== 6'd20) begin errors++; $display("[TB] FAIL exact_credit20: got %0d expected 20", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("[TB] FAIL exact_dispense: got %b expected 1", dispense); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL exact_busy: got %b expected 1", busy); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (dispense !== 1'b0) begin errors++; $display("[TB] FAIL exact_dispense_end: got %b expected 0", dispense); end
      checks++; if (change5 !== 1'b0) begin errors++; $display("[TB] FAIL exact_no_change: got %b expected 0", change5); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL exact_credit_end: got %0d expected 0", credit); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL exact_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_overpay();
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (credit !== 6'd15) begin errors++; $display("[TB] FAIL over_credit15: got %0d expected 15", credit); end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (credit !== 6'd25) begin errors++; $display("[TB] FAIL over_credit25: got %0d expected 25", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("[TB] FAIL over_dispense: got %b expected 1", dispense); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (change5 !== 1'b1) begin errors++; $display("[TB] FAIL over_change: got %b expected 1", change5); end
      checks++; if (credit !== 6'd5) begin errors++; $display("[TB] FAIL over_credit5: got %0d expected 5", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("[TB] FAIL over_dispense_end: got %b expected 0", dispense); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (change5 !== 1'b0) begin errors++; $display("[TB] FAIL over_change_end: got %b expected 0", change5); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL over_credit_end: got %0d expected 0", credit); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL over_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_cancel();
      int pulses;
      doReset();
      // Cancel with nothing held does nothing but reject the coin offered with it.
      applyStimulus(1'b1, 1'b0, 1'b1);
      checks++; if (coinReject !== 1'b1) begin errors++; $display("[TB] FAIL cancel0_reject: got %b expected 1", coinReject); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel0_busy: got %b expected 0", busy); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL cancel0_credit: got %0d expected 0", credit); end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (coinReject !== 1'b0) begin errors++; $display("[TB] FAIL cancel_reject_clear: got %b expected 0", coinReject); end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (credit !== 6'd15) begin errors++; $display("[TB] FAIL cancel_credit15: got %0d expected 15", credit); end
      applyStimulus(1'b0, 1'b0, 1'b1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (change5 === 1'b1) pulses++;
         checks++; if (dispense !== 1'b0) begin errors++; $display("[TB] FAIL cancel_no_dispense: got %b expected 0 at cycle %0d", dispense, i); end
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (i == 0) begin
            checks++; if (credit !== 6'd10) begin errors++; $display("[TB] FAIL cancel_credit10: got %0d expected 10", credit); end
         end
      end
      checks++; if (pulses !== 3) begin errors++; $display("[TB] FAIL cancel_pulses: got %0d expected 3", pulses); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL cancel_credit_end: got %0d expected 0", credit); end
   endtask

   task automatic test_ceiling();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (credit2 !== 6'd15) begin errors++; $display("[TB] FAIL ceil_credit15: got %0d expected 15", credit2); end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (coinReject2 !== 1'b1) begin errors++; $display("[TB] FAIL ceil_reject: got %b expected 1", coinReject2); end
      checks++; if (credit2 !== 6'd15) begin errors++; $display("[TB] FAIL ceil_credit_hold: got %0d expected 15", credit2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL ceil_busy: got %b expected 0", busy2); end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (credit2 !== 6'd20) begin errors++; $display("[TB] FAIL ceil_credit20: got %0d expected 20", credit2); end
      checks++; if (dispense2 !== 1'b1) begin errors++; $display("[TB] FAIL ceil_dispense: got %b expected 1", dispense2); end
      checks++; if (coinReject2 !== 1'b0) begin errors++; $display("[TB] FAIL ceil_reject_clear: got %b expected 0", coinReject2); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (credit2 !== 6'd0) begin errors++; $display("[TB] FAIL ceil_credit_end: got %0d expected 0", credit2); end
      checks++; if (change52 !== 1'b0) begin errors++; $display("[TB] FAIL ceil_no_change: got %b expected 0", change52); end
   endtask

   task automatic test_simultaneous();
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checks++; if (credit !== 6'd25) begin errors++; $display("[TB] FAIL simul_credit25: got %0d expected 25", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("[TB] FAIL simul_dispense: got %b expected 1", dispense); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (change5 !== 1'b1) begin errors++; $display("[TB] FAIL simul_change: got %b expected 1", change5); end
      // A coin offered during the only RETURN cycle is rejected and does
      // not extend the payout.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (coinReject !== 1'b1) begin errors++; $display("[TB] FAIL simul_busy_reject: got %b expected 1", coinReject); end
      checks++; if (change5 !== 1'b0) begin errors++; $display("[TB] FAIL simul_change_end: got %b expected 0", change5); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL simul_credit_end: got %0d expected 0", credit); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (coinReject !== 1'b0) begin errors++; $display("[TB] FAIL simul_reject_clear: got %b expected 0", coinReject); end
   endtask

   task automatic test_back_to_back();
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (dispense !== 1'b1) begin errors++; $display("[TB] FAIL b2b_dispense: got %b expected 1", dispense); end
      // Coin during DISPENSE is rejected; the machine is back in COLLECT after.
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++; if (coinReject !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reject: got %b expected 1", coinReject); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL b2b_credit0: got %0d expected 0", credit); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 0", busy); end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++; if (credit !== 6'd5) begin errors++; $display("[TB] FAIL b2b_accept: got %0d expected 5", credit); end
   endtask

   task automatic test_reset_mid_return();
      int pulses;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checks++; if (change5 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_change: got %b expected 1", change5); end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++; if (credit !== 6'd10) begin errors++; $display("[TB] FAIL midrst_credit10: got %0d expected 10", credit); end
      doReset();
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL midrst_credit: got %0d expected 0", credit); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (change5 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_change_off: got %b expected 0", change5); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (change5 === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL midrst_pulses: got %0d expected 0", pulses); end
   endtask

   // Scenario sequence.
   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      coin5     = 1'b0;
      coin10    = 1'b0;
      cancelReq = 1'b0;
      @(negedge clk);
      test_reset();
      test_exact_price();
      test_overpay();
      test_cancel();
      test_ceiling();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_return();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
